// File: rtl/cim_weight_loader.sv
// cim_weight_loader
// Write sequencer for a two-bank CIM storage array. Takes 24-bit weight words
// over a valid/ready handshake and writes them row 0..ROWS-1 into each selected
// bank (bank 0 first) using a SETUP / PULSE / HOLD word-line protocol.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready are
// both high. in_ready is a registered decode of the FETCH state, so it never
// depends combinationally on in_valid. Upstream must hold in_data stable while
// in_valid is high and in_ready is low. If abort is sampled in FETCH, it takes
// priority over any word that is offered in the same cycle. In that case the
// word counts as consumed and is dropped, and it is never written.
//
// All outputs are registered. Each one is decoded from the next-state value, so
// it changes on the same edge as the state it belongs to.
module cim_weight_loader #(
   parameter int DW       = 24,
   parameter int ROWS     = 8,
   parameter int HOLD_CYC = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      bank_mask,
   input  logic            abort,
   input  logic            in_valid,
   input  logic [DW-1:0]   in_data,
   output logic            in_ready,
   output logic [ROWS-1:0] WA0,
   output logic [ROWS-1:0] WA1,
   output logic [DW-1:0]   D,
   output logic            busy,
   output logic            done,
   output logic            aborted
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [RW-1:0]   ROW_LAST  = RW'(ROWS - 1);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYC - 1);
   localparam logic [ROWS-1:0] ROW0_SEL  = ROWS'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_SETUP = 3'd2,
      S_PULSE = 3'd3,
      S_HOLD  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic            mask1_q, mask1_d;       // bank 1 is still to be loaded after bank 0
   logic            bank_q, bank_d;         // current bank: 0 or 1
   logic [RW-1:0]   row_q, row_d;
   logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
   logic            abort_pend_q, abort_pend_d;  // abort seen during PULSE/HOLD
   logic [DW-1:0]   d_q, d_d;
   logic [ROWS-1:0] wa0_q, wa0_d;
   logic [ROWS-1:0] wa1_q, wa1_d;
   logic            in_ready_q, in_ready_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            aborted_q, aborted_d;
   logic            end_abort;

   // Next-state, counter and registered-output computation
   always_comb begin
      state_d      = state_q;
      mask1_d      = mask1_q;
      bank_d       = bank_q;
      row_d        = row_q;
      hold_cnt_d   = hold_cnt_q;
      abort_pend_d = abort_pend_q;
      d_d          = d_q;
      end_abort    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // abort is ignored here, so a start in the same cycle always wins
            if (start) begin
               if (bank_mask != 2'b00) begin
                  mask1_d      = bank_mask[1];
                  bank_d       = ~bank_mask[0];
                  row_d        = '0;
                  hold_cnt_d   = '0;
                  abort_pend_d = 1'b0;
                  state_d      = S_FETCH;
               end else begin
                  state_d = S_DONE;
               end
            end
         end

         S_FETCH: begin
            if (abort) begin
               end_abort = 1'b1;
               state_d   = S_DONE;
            end else if (in_valid) begin
               d_d     = in_data;
               state_d = S_SETUP;
            end
         end

         S_SETUP: begin
            // The word has not reached a word line yet, so it can be dropped
            if (abort) begin
               end_abort = 1'b1;
               state_d   = S_DONE;
            end else begin
               state_d = S_PULSE;
            end
         end

         S_PULSE: begin
            // A pulse is never cut short. Remember the abort and finish the row.
            if (abort) begin
               abort_pend_d = 1'b1;
            end
            hold_cnt_d = '0;
            state_d    = S_HOLD;
         end

         S_HOLD: begin
            if (abort) begin
               abort_pend_d = 1'b1;
            end
            if (hold_cnt_q == HOLD_LAST) begin
               hold_cnt_d = '0;
               if (abort_pend_d) begin
                  end_abort = 1'b1;
                  state_d   = S_DONE;
               end else if (row_q != ROW_LAST) begin
                  row_d   = row_q + RW'(1);
                  state_d = S_FETCH;
               end else if (!bank_q && mask1_q) begin
                  bank_d  = 1'b1;
                  row_d   = '0;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
         end

         S_DONE: begin
            abort_pend_d = 1'b0;
            state_d      = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs decoded from the state being entered
      busy_d     = (state_d == S_FETCH) || (state_d == S_SETUP) ||
                   (state_d == S_PULSE) || (state_d == S_HOLD);
      in_ready_d = (state_d == S_FETCH);
      done_d     = (state_d == S_DONE);
      aborted_d  = (state_d == S_DONE) && end_abort;
      wa0_d      = '0;
      wa1_d      = '0;
      if (state_d == S_PULSE) begin
         if (bank_d) begin
            wa1_d = ROW0_SEL << row_d;
         end else begin
            wa0_d = ROW0_SEL << row_d;
         end
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         mask1_q      <= 1'b0;
         bank_q       <= 1'b0;
         row_q        <= '0;
         hold_cnt_q   <= '0;
         abort_pend_q <= 1'b0;
         d_q          <= '0;
         wa0_q        <= '0;
         wa1_q        <= '0;
         in_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         mask1_q      <= mask1_d;
         bank_q       <= bank_d;
         row_q        <= row_d;
         hold_cnt_q   <= hold_cnt_d;
         abort_pend_q <= abort_pend_d;
         d_q          <= d_d;
         wa0_q        <= wa0_d;
         wa1_q        <= wa1_d;
         in_ready_q   <= in_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
      end
   end

   assign in_ready = in_ready_q;
   assign WA0      = wa0_q;
   assign WA1      = wa1_q;
   assign D        = d_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign aborted  = aborted_q;

endmodule

// File: tb/tb_cim_weight_loader.sv
// tb_cim_weight_loader
// Table-driven bench for cim_weight_loader at its default parameters.
// Cycle numbering inside a load: the cycle in which start is driven is cycle 1.
// With no stalls, global row g (0-based, counted across banks) uses these
// cycles: FETCH in cycle 2+4g, SETUP in 3+4g, PULSE in 4+4g, HOLD in 5+4g.
module tb_cim_weight_loader;

   localparam int DW   = 24;
   localparam int ROWS = 8;

   // ---------------- clock / reset ----------------
   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [1:0]      bank_mask;
   logic            abort;
   logic            in_valid;
   logic [DW-1:0]   in_data;
   logic            in_ready;
   logic [ROWS-1:0] wa0;
   logic [ROWS-1:0] wa1;
   logic [DW-1:0]   d;
   logic            busy;
   logic            done;
   logic            aborted;

   always #5 clk = ~clk;

   cim_weight_loader #(.DW(DW), .ROWS(ROWS), .HOLD_CYC(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bank_mask (bank_mask),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .WA0       (wa0),
      .WA1       (wa1),
      .D         (d),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted)
   );

   // ---------------- scoreboard ----------------
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [39:0] exp_q[$];   // {WA0, WA1, D} for each expected write pulse

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Expected write order: bank 0 rows 0..7, then bank 1 rows 0..7, only for the
   // banks in the mask; word values count up from 1. Only the first n writes are kept.
   task automatic build_exp(input logic [1:0] mask, input int n);
      int g;
      logic [7:0] sel;
      logic [7:0] one;
      one = 8'h01;
      g   = 0;
      exp_q.delete();
      for (int b = 0; b < 2; b++) begin
         if (mask[b]) begin
            for (int r = 0; r < ROWS; r++) begin
               sel = one << r;
               if (g < n) begin
                  if (b == 0) exp_q.push_back({sel, 8'h00, 24'(g + 1)});
                  else        exp_q.push_back({8'h00, sel, 24'(g + 1)});
               end
               g++;
            end
         end
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0] mask;
      int         stall_word;      // word number to withhold (0 = none)
      int         stall_len;       // cycles withheld while in_ready is high
      int         abort_cyc;       // cycle in which abort is pulsed (0 = none)
      int         busy_start_cyc;  // cycle in which a stray start/mask 11 is pulsed (0 = none)
      bit         start_abort;     // drive abort together with start
      int         exp_done;        // cycle in which done is expected
      bit         exp_ab;
      int         exp_writes;
   } vec_t;

   // ---------------- driver ----------------
   task automatic run_vec(input vec_t v, input int idx);
      int   cyc;
      int   w;
      int   stall_cnt;
      int   done_cyc;
      bit   hs;
      bit   seen_ready;
      bit   got_done;
      logic ab;
      logic [39:0] e;

      build_exp(v.mask, v.exp_writes);
      @(negedge clk);
      start      = 1'b1;
      bank_mask  = v.mask;
      abort      = v.start_abort;
      in_valid   = 1'b1;
      in_data    = 24'd1;
      w          = 1;
      cyc        = 1;
      hs         = 1'b0;
      seen_ready = 1'b0;
      got_done   = 1'b0;
      stall_cnt  = 0;
      done_cyc   = 0;
      ab         = 1'b0;

      while (!got_done && cyc < 300) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         abort = 1'b0;
         bank_mask = v.mask;
         if (hs) w++;
         if (cyc == v.busy_start_cyc) begin
            start     = 1'b1;
            bank_mask = 2'b11;
         end
         if (cyc == v.abort_cyc) abort = 1'b1;

         // observe the outputs of this cycle
         if (in_ready) seen_ready = 1'b1;
         check($sformatf("v%0d_onehot_c%0d", idx, cyc), 64'($countones({wa0, wa1}) <= 1), 64'(1));
         if ((wa0 | wa1) != '0) begin
            if (exp_q.size() == 0) begin
               check($sformatf("v%0d_extra_write_c%0d", idx, cyc), 64'({wa0, wa1, d}), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check($sformatf("v%0d_write_c%0d", idx, cyc), 64'({wa0, wa1, d}), 64'(e));
            end
         end
         if (done) begin
            got_done = 1'b1;
            done_cyc = cyc;
            ab       = aborted;
            check($sformatf("v%0d_busy_at_done", idx), 64'(busy), 64'(0));
         end

         // source: withhold one word for stall_len cycles once it is being fetched
         if (stall_cnt > 0 && stall_cnt < v.stall_len) begin
            check($sformatf("v%0d_stall_ready_c%0d", idx, cyc), 64'(in_ready), 64'(1));
            in_valid = 1'b0;
            stall_cnt++;
         end else if (stall_cnt == 0 && v.stall_len > 0 && w == v.stall_word && in_ready) begin
            in_valid  = 1'b0;
            stall_cnt = 1;
         end else begin
            in_valid = 1'b1;
            in_data  = 24'(w);
         end
         hs = in_valid && in_ready;
      end

      check($sformatf("v%0d_done_seen", idx), 64'(got_done), 64'(1));
      check($sformatf("v%0d_done_cycle", idx), 64'(done_cyc), 64'(v.exp_done));
      check($sformatf("v%0d_aborted", idx), 64'(ab), 64'(v.exp_ab));
      check($sformatf("v%0d_missing_writes", idx), 64'(exp_q.size()), 64'(0));
      if (v.mask == 2'b00) check($sformatf("v%0d_ready_never", idx), 64'(seen_ready), 64'(0));

      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d_done_one_cycle", idx), 64'(done), 64'(0));
      check($sformatf("v%0d_idle_busy", idx), 64'(busy), 64'(0));
   endtask

   // ---------------- test ----------------
   vec_t vecs[10];
   int   guard;

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      bank_mask = 2'b00;
      abort     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;

      //           mask   stw stl abc  bsc sab done ab writes
      vecs[0] = '{2'b11, 0,  0,  0,   0,  1'b0, 66, 1'b0, 16};  // full two-bank load
      vecs[1] = '{2'b10, 0,  0,  0,   0,  1'b0, 34, 1'b0, 8};   // bank 1 only
      vecs[2] = '{2'b01, 4,  5,  0,   0,  1'b0, 39, 1'b0, 8};   // 5-cycle stall before row 3
      vecs[3] = '{2'b11, 0,  0,  20,  0,  1'b0, 22, 1'b1, 5};   // abort in PULSE of bank0 row 4
      vecs[4] = '{2'b01, 0,  0,  0,   0,  1'b0, 34, 1'b0, 8};   // restart from row 0 after abort
      vecs[5] = '{2'b00, 0,  0,  0,   0,  1'b0, 2,  1'b0, 0};   // empty mask
      vecs[6] = '{2'b01, 0,  0,  0,   10, 1'b0, 34, 1'b0, 8};   // start while busy is ignored
      vecs[7] = '{2'b10, 0,  0,  0,   0,  1'b1, 34, 1'b0, 8};   // start beats abort in IDLE
      vecs[8] = '{2'b11, 0,  0,  19,  0,  1'b0, 20, 1'b1, 4};   // abort in SETUP drops row 4
      vecs[9] = '{2'b11, 0,  0,  48,  0,  1'b0, 50, 1'b1, 12};  // abort in PULSE of bank1 row 3

      repeat (3) @(negedge clk);
      check("reset_wa0", 64'(wa0), 64'(0));
      check("reset_wa1", 64'(wa1), 64'(0));
      check("reset_d", 64'(d), 64'(0));
      check("reset_ctrl", 64'({in_ready, busy, done, aborted}), 64'(0));
      rst = 1'b0;

      // abort alone in IDLE does nothing
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("idle_abort_ctrl", 64'({in_ready, busy, done, aborted}), 64'(0));

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // reset in the middle of a load, during HOLD of bank0 row 2
      @(negedge clk);
      start     = 1'b1;
      bank_mask = 2'b01;
      in_valid  = 1'b1;
      in_data   = 24'h00abcd;
      guard     = 0;
      @(negedge clk);
      start = 1'b0;
      while (wa0 != 8'h04 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      check("rst_reach_row2", 64'(wa0), 64'(8'h04));
      @(negedge clk);   // HOLD
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_wa", 64'({wa0, wa1}), 64'(0));
      check("rst_mid_d", 64'(d), 64'(0));
      check("rst_mid_ctrl", 64'({in_ready, busy, done, aborted}), 64'(0));
      rst      = 1'b0;
      in_valid = 1'b0;
      run_vec('{2'b01, 0, 0, 0, 0, 1'b0, 34, 1'b0, 8}, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
